elastic_buffer_n: RTL and testbench



---
 rtl/elastic_buffer_n.sv | 157 +++++++++++++++
 tb/tb_elastic_buffer_n.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_buffer_n.sv
// ----------------------------------------------------------------------------
// elastic_buffer_n
//
// DEPTH-entry elastic buffer on a valid/ready stream. ready_in is derived from
// registered state (plus the synchronous reset/flush controls), so there is
// no combinational path from ready_out back to ready_in.
//
// Handshake: a transfer happens on an interface in any cycle where both its
// valid and ready are high at the rising edge of clk
// (push = valid_in & ready_in, pop = valid_out & ready_out). valid_out never
// depends on ready_out, and data_out is held stable while valid_out is high
// and not popped.
//
// Parameters:
//   DATA_W    payload width in bits
//   DEPTH     number of storage entries (2..256, any value)
//   AF_THRESH almost_full asserts when count >= AF_THRESH (1..DEPTH)
//   BYPASS    1 = empty buffer passes input straight to output
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   flush_in        synchronous discard of all stored entries
//   valid_in, ready_in, data_in     upstream side
//   valid_out, ready_out, data_out  downstream side
//   count, full, almost_full        occupancy reporting
//   write_en, read_en               debug strobes for storage write / removal
// ----------------------------------------------------------------------------
module elastic_buffer_n #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int BYPASS    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_in,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       almost_full,
    output logic                       write_en,
    output logic                       read_en
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF_THRESH = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);
    localparam logic             C_BYPASS    = (BYPASS != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_ready;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_bypass_xfer;
    logic              w_write;
    logic              w_read;
    logic [DATA_W-1:0] w_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // Only registered occupancy and the synchronous controls feed ready_in.
    assign w_ready = !w_full && !flush_in && !reset;

    // When empty and bypassing, the upstream valid is presented directly.
    assign w_valid = !reset && !flush_in &&
                     (!w_empty || (C_BYPASS && valid_in));

    assign w_push = valid_in && w_ready;
    assign w_pop  = w_valid && ready_out;

    // An empty bypass buffer whose input is consumed in the same cycle
    // never touches storage.
    assign w_bypass_xfer = C_BYPASS && w_empty && w_push && w_pop;

    assign w_write = w_push && !w_bypass_xfer;
    assign w_read  = w_pop && !w_empty;

    // data_out is zeroed whenever nothing valid is presented.
    always_comb begin
        w_data = '0;
        if (w_valid) begin
            if (w_empty) begin
                w_data = data_in;
            end else begin
                w_data = r_mem[r_rd_ptr];
            end
        end
    end

    // Storage array carries no reset; only entries below count are observable.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (w_write) begin
                if (r_wr_ptr == C_PTR_LAST) begin
                    r_wr_ptr <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
            end
            if (w_read) begin
                if (r_rd_ptr == C_PTR_LAST) begin
                    r_rd_ptr <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
            end
            if (w_write && !w_read) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_read && !w_write) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    assign ready_in    = w_ready;
    assign valid_out   = w_valid;
    assign data_out    = w_data;
    assign count       = r_count;
    assign full        = w_full;
    assign almost_full = (r_count >= C_AF_THRESH);
    assign write_en    = w_write;
    assign read_en     = w_read;

endmodule

// File: tb/tb_elastic_buffer_n.sv
// ----------------------------------------------------------------------------
// tb_elastic_buffer_n
//
// Three instances of elastic_buffer_n on a shared clock and reset:
//   u_a : DEPTH=4, AF_THRESH=2, BYPASS=0  (fill/drain, streaming, flush, reset)
//   u_b : DEPTH=3, BYPASS=0               (pointer wrap with stalls)
//   u_c : DEPTH=4, BYPASS=1               (empty bypass)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_elastic_buffer_n;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A ----------------
    logic       a_flush = 1'b0, a_vin = 1'b0, a_rout = 1'b0;
    logic [7:0] a_din = '0;
    logic       a_rdy, a_vout, a_full, a_af, a_we, a_re;
    logic [7:0] a_dout;
    logic [2:0] a_cnt;

    elastic_buffer_n #(.DATA_W(8), .DEPTH(4), .AF_THRESH(2), .BYPASS(0)) u_a (
        .clk(clk), .reset(reset), .flush_in(a_flush),
        .valid_in(a_vin), .ready_in(a_rdy), .data_in(a_din),
        .valid_out(a_vout), .ready_out(a_rout), .data_out(a_dout),
        .count(a_cnt), .full(a_full), .almost_full(a_af),
        .write_en(a_we), .read_en(a_re)
    );

    // ---------------- instance B ----------------
    logic       b_flush = 1'b0, b_vin = 1'b0, b_rout = 1'b0;
    logic [7:0] b_din = '0;
    logic       b_rdy, b_vout, b_full, b_af, b_we, b_re;
    logic [7:0] b_dout;
    logic [1:0] b_cnt;

    elastic_buffer_n #(.DATA_W(8), .DEPTH(3), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .flush_in(b_flush),
        .valid_in(b_vin), .ready_in(b_rdy), .data_in(b_din),
        .valid_out(b_vout), .ready_out(b_rout), .data_out(b_dout),
        .count(b_cnt), .full(b_full), .almost_full(b_af),
        .write_en(b_we), .read_en(b_re)
    );

    // ---------------- instance C ----------------
    logic       c_flush = 1'b0, c_vin = 1'b0, c_rout = 1'b0;
    logic [7:0] c_din = '0;
    logic       c_rdy, c_vout, c_full, c_af, c_we, c_re;
    logic [7:0] c_dout;
    logic [2:0] c_cnt;

    elastic_buffer_n #(.DATA_W(8), .DEPTH(4), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset), .flush_in(c_flush),
        .valid_in(c_vin), .ready_in(c_rdy), .data_in(c_din),
        .valid_out(c_vout), .ready_out(c_rout), .data_out(c_dout),
        .count(c_cnt), .full(c_full), .almost_full(c_af),
        .write_en(c_we), .read_en(c_re)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({a_rdy, a_vout, a_dout, a_we, a_re} !== 12'h0) begin
            n_errors++;
            $display("FAIL reset_held_a: got rdy=%b vout=%b dout=%h we=%b re=%b want all 0",
                     a_rdy, a_vout, a_dout, a_we, a_re);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_rdy, a_full, a_af, a_vout} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_release_a: got cnt=%0d rdy=%b full=%b af=%b vout=%b want 0 1 0 0 0",
                     a_cnt, a_rdy, a_full, a_af, a_vout);
        end
        n_checks++;
        if ({b_cnt, b_rdy, c_cnt, c_rdy} !== {2'd0, 1'b1, 3'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_release_bc: got b_cnt=%0d b_rdy=%b c_cnt=%0d c_rdy=%b want 0 1 0 1",
                     b_cnt, b_rdy, c_cnt, c_rdy);
        end
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        a_rout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_vin = 1'b1;
            a_din = vals[i];
            @(negedge clk);
            n_checks++;
            if ({a_cnt, a_rdy, a_we, a_af} !== {3'(i), 1'b1, 1'b1, (i >= 2)}) begin
                n_errors++;
                $display("FAIL fill_step%0d: got cnt=%0d rdy=%b we=%b af=%b want %0d 1 1 %b",
                         i, a_cnt, a_rdy, a_we, a_af, i, (i >= 2));
            end
            tick();
        end
        // Fifth cycle: buffer full, this 0x99 must be refused.
        a_din = 8'h99;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_full, a_rdy, a_af, a_we} !== {3'd4, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL fill_full: got cnt=%0d full=%b rdy=%b af=%b we=%b want 4 1 0 1 0",
                     a_cnt, a_full, a_rdy, a_af, a_we);
        end
        tick();
        a_vin = 1'b0;
        a_rout = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_vout, a_dout, a_re, a_cnt, a_rdy} !== {1'b1, vals[i], 1'b1, 3'(4 - i), (i != 0)}) begin
                n_errors++;
                $display("FAIL drain_step%0d: got vout=%b dout=%h re=%b cnt=%0d rdy=%b want 1 %h 1 %0d %b",
                         i, a_vout, a_dout, a_re, a_cnt, a_rdy, vals[i], 4 - i, (i != 0));
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_vout, a_dout} !== {3'd0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL drain_empty: got cnt=%0d vout=%b dout=%h want 0 0 00", a_cnt, a_vout, a_dout);
        end
        a_rout = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_streaming();
        logic [13:0] got;
        logic [13:0] want;
        a_rout = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            a_vin = (k < 20);
            a_din = 8'h30 + 8'(k);
            @(negedge clk);
            got = {a_vout, a_dout, a_cnt, a_we, a_re};
            if (k == 0) begin
                want = {1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
            end else if (k < 20) begin
                want = {1'b1, 8'h30 + 8'(k - 1), 3'd1, 1'b1, 1'b1};
            end else begin
                want = {1'b1, 8'h30 + 8'(k - 1), 3'd1, 1'b0, 1'b1};
            end
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL stream_cycle%0d: got {vout,dout,cnt,we,re}=%h want %h", k, got, want);
            end
            tick();
        end
        a_vin = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_vout} !== {3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL stream_end: got cnt=%0d vout=%b want 0 0", a_cnt, a_vout);
        end
        a_rout = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_wrap();
        logic [7:0]  exp_q[$];
        logic [23:0] vin_pat;
        logic [23:0] rout_pat;
        int          m_cnt;
        int          n_in;
        int          n_out;
        logic [7:0]  next_d;
        logic        exp_rdy;
        logic        exp_vout;
        vin_pat  = 24'b1111_0110_1110_1011_1101_1111;
        rout_pat = 24'b0001_1010_1101_0110_1011_0111;
        m_cnt  = 0;
        n_in   = 0;
        n_out  = 0;
        next_d = 8'hB0;
        for (int i = 0; i < 30; i++) begin
            b_vin  = (i < 24) ? vin_pat[i] : 1'b0;
            b_rout = (i < 24) ? rout_pat[i] : 1'b1;
            b_din  = next_d;
            @(negedge clk);
            exp_rdy  = (m_cnt < 3);
            exp_vout = (m_cnt != 0);
            n_checks++;
            if ({b_cnt, b_rdy, b_vout} !== {2'(m_cnt), exp_rdy, exp_vout}) begin
                n_errors++;
                $display("FAIL wrap_state%0d: got cnt=%0d rdy=%b vout=%b want %0d %b %b",
                         i, b_cnt, b_rdy, b_vout, m_cnt, exp_rdy, exp_vout);
            end
            if (exp_vout) begin
                n_checks++;
                if (b_dout !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL wrap_data%0d: got %h want %h", i, b_dout, exp_q[0]);
                end
            end
            if (b_rout && exp_vout) begin
                void'(exp_q.pop_front());
                m_cnt--;
                n_out++;
            end
            if (b_vin && exp_rdy) begin
                exp_q.push_back(next_d);
                next_d = next_d + 8'd1;
                m_cnt++;
                n_in++;
            end
            tick();
        end
        n_checks++;
        if (n_in != n_out || n_in < 10 || b_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL wrap_totals: got in=%0d out=%0d cnt=%0d want equal, >=10, cnt 0",
                     n_in, n_out, b_cnt);
        end
        b_vin  = 1'b0;
        b_rout = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_flush();
        a_rout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_vin = 1'b1;
            a_din = 8'h61 + 8'(i);
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (a_cnt !== 3'd3) begin
            n_errors++;
            $display("FAIL flush_precount: got %0d want 3", a_cnt);
        end
        tick();
        // The loop left valid_in high for one more cycle; count may now be 4.
        a_flush = 1'b1;
        a_vin   = 1'b1;
        a_din   = 8'h55;
        a_rout  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_vout, a_rdy, a_we, a_re, a_dout} !== 12'h0) begin
            n_errors++;
            $display("FAIL flush_cycle: got vout=%b rdy=%b we=%b re=%b dout=%h want all 0",
                     a_vout, a_rdy, a_we, a_re, a_dout);
        end
        tick();
        a_flush = 1'b0;
        a_vin   = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_vout, a_rdy} !== {3'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL flush_after: got cnt=%0d vout=%b rdy=%b want 0 0 1", a_cnt, a_vout, a_rdy);
        end
        tick();
        a_vin = 1'b1;
        a_din = 8'h77;
        tick();
        a_vin = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_vout, a_dout, a_cnt} !== {1'b1, 8'h77, 3'd1}) begin
            n_errors++;
            $display("FAIL flush_first_push: got vout=%b dout=%h cnt=%0d want 1 77 1", a_vout, a_dout, a_cnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({a_vout, a_cnt} !== {1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL flush_drained: got vout=%b cnt=%0d want 0 0", a_vout, a_cnt);
        end
        a_rout = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_bypass();
        c_vin  = 1'b1;
        c_din  = 8'hA5;
        c_rout = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({c_vout, c_dout, c_we, c_re, c_cnt} !== {1'b1, 8'hA5, 1'b0, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL bypass_through: got vout=%b dout=%h we=%b re=%b cnt=%0d want 1 a5 0 0 0",
                     c_vout, c_dout, c_we, c_re, c_cnt);
        end
        tick();
        c_rout = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({c_cnt, c_vout, c_dout, c_we} !== {3'd0, 1'b1, 8'hA5, 1'b1}) begin
            n_errors++;
            $display("FAIL bypass_store: got cnt=%0d vout=%b dout=%h we=%b want 0 1 a5 1",
                     c_cnt, c_vout, c_dout, c_we);
        end
        tick();
        c_vin = 1'b0;
        c_din = 8'h00;
        @(negedge clk);
        n_checks++;
        if ({c_cnt, c_vout, c_dout} !== {3'd1, 1'b1, 8'hA5}) begin
            n_errors++;
            $display("FAIL bypass_held: got cnt=%0d vout=%b dout=%h want 1 1 a5", c_cnt, c_vout, c_dout);
        end
        tick();
        // Stored entry leaves while a new one enters storage.
        c_vin  = 1'b1;
        c_din  = 8'h5A;
        c_rout = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({c_dout, c_we, c_re} !== {8'hA5, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL bypass_swap: got dout=%h we=%b re=%b want a5 1 1", c_dout, c_we, c_re);
        end
        tick();
        c_vin = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({c_cnt, c_dout, c_re} !== {3'd1, 8'h5A, 1'b1}) begin
            n_errors++;
            $display("FAIL bypass_second: got cnt=%0d dout=%h re=%b want 1 5a 1", c_cnt, c_dout, c_re);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({c_cnt, c_vout, c_dout} !== {3'd0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL bypass_idle: got cnt=%0d vout=%b dout=%h want 0 0 00", c_cnt, c_vout, c_dout);
        end
        c_rout = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid();
        a_rout = 1'b0;
        a_vin  = 1'b1;
        a_din  = 8'h81;
        tick();
        a_din = 8'h82;
        tick();
        a_vin = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_af} !== {3'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL rstmid_pre: got cnt=%0d af=%b want 2 1", a_cnt, a_af);
        end
        tick();
        reset  = 1'b1;
        a_vin  = 1'b1;
        a_din  = 8'h83;
        a_rout = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_rdy, a_vout, a_dout, a_we, a_re} !== 12'h0) begin
            n_errors++;
            $display("FAIL rstmid_held: got rdy=%b vout=%b dout=%h we=%b re=%b want all 0",
                     a_rdy, a_vout, a_dout, a_we, a_re);
        end
        tick();
        reset  = 1'b0;
        a_din  = 8'h91;
        a_rout = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_af, a_rdy, a_we} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL rstmid_after: got cnt=%0d af=%b rdy=%b we=%b want 0 0 1 1",
                     a_cnt, a_af, a_rdy, a_we);
        end
        tick();
        a_vin  = 1'b0;
        a_rout = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_vout, a_dout, a_cnt} !== {1'b1, 8'h91, 3'd1}) begin
            n_errors++;
            $display("FAIL rstmid_first_out: got vout=%b dout=%h cnt=%0d want 1 91 1", a_vout, a_dout, a_cnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({a_cnt, a_vout} !== {3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL rstmid_empty: got cnt=%0d vout=%b want 0 0", a_cnt, a_vout);
        end
        a_rout = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_wrap();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
